// File: rtl/alu_multicycle_ctrl.sv
// EX-stage sequencer: classifies ALU ops, launches multi-cycle units, stalls the pipe until they finish.
// Latency: single-cycle ops complete same cycle; MUL/FP ops stall L cycles and present the result in cycle L.
module alu_multicycle_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int FP_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [5:0]  ALU_operation,
  input  logic        flush,
  output logic        mul_start,
  output logic        fp_start,
  output logic [5:0]  op_latched,
  output logic        ex_stall,
  output logic [1:0]  result_sel,
  output logic        result_valid,
  output logic        illegal_op,
  output logic [31:0] stall_count
);

  localparam int MAX_LAT = (MUL_LAT > FP_LAT) ? MUL_LAT : FP_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] FP_LOAD  = CW'(FP_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   stall_count_q, stall_count_d;

  logic is_alu, is_mul, is_fp, is_ill, take;
  logic [CW-1:0] load_val;

  assign is_alu = (ALU_operation[5:4] == 2'b00);
  assign is_mul = (ALU_operation[5:2] == 4'b0100);
  assign is_fp  = (ALU_operation == 6'b110000) || (ALU_operation == 6'b110001);
  assign is_ill = ~(is_alu | is_mul | is_fp);
  assign take   = (state_q == S_IDLE) & ex_valid & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    load_val = is_mul ? MUL_LOAD : FP_LOAD;
    case (state_q)
      S_IDLE: begin
        if (take && (is_mul || is_fp)) begin
          op_d    = ALU_operation;
          cnt_d   = load_val;
          state_d = (load_val == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    stall_count_d = stall_count_q + {31'b0, ex_stall};
  end

  always_comb begin
    mul_start    = 1'b0;
    fp_start     = 1'b0;
    ex_stall     = 1'b0;
    result_valid = 1'b0;
    result_sel   = 2'b00;
    illegal_op   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          if (is_alu) begin
            result_valid = 1'b1;
          end else if (is_mul) begin
            mul_start = 1'b1;
            ex_stall  = 1'b1;
          end else if (is_fp) begin
            fp_start = 1'b1;
            ex_stall = 1'b1;
          end else begin
            illegal_op = is_ill;
          end
        end
      end
      S_BUSY: ex_stall = 1'b1;
      S_DONE: begin
        // A flush in the result cycle kills the writeback but the unit select still follows the op.
        result_valid = ~flush;
        result_sel   = op_q[5] ? 2'b11 : 2'b01;
      end
      default: ;
    endcase
  end

  assign op_latched  = op_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Directed bench for alu_multicycle_ctrl: vector table over a default instance plus a MUL_LAT=1 instance.
module tb_alu_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, flush;
  logic [5:0]  alu_op;
  logic        mul_start, fp_start, ex_stall, result_valid, illegal_op;
  logic [5:0]  op_latched;
  logic [1:0]  result_sel;
  logic [31:0] stall_count;

  logic        v1, f1;
  logic [5:0]  op1;
  logic        ms1, fs1, st1, rv1, il1;
  logic [5:0]  ol1;
  logic [1:0]  sel1;
  logic [31:0] sc1;

  int total = 0;
  int bad   = 0;

  alu_multicycle_ctrl #(.MUL_LAT(3), .FP_LAT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ALU_operation(alu_op), .flush(flush),
    .mul_start(mul_start), .fp_start(fp_start), .op_latched(op_latched), .ex_stall(ex_stall),
    .result_sel(result_sel), .result_valid(result_valid), .illegal_op(illegal_op),
    .stall_count(stall_count)
  );

  alu_multicycle_ctrl #(.MUL_LAT(1), .FP_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(v1), .ALU_operation(op1), .flush(f1),
    .mul_start(ms1), .fp_start(fs1), .op_latched(ol1), .ex_stall(st1),
    .result_sel(sel1), .result_valid(rv1), .illegal_op(il1), .stall_count(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] op;
    logic       f;
    logic       ms;
    logic       fs;
    logic       st;
    logic       rv;
    logic [1:0] sel;
    logic       il;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(input logic v, input logic [5:0] op, input logic f,
                              input logic ms, input logic fs, input logic st,
                              input logic rv, input logic [1:0] sel, input logic il);
    vec_t r;
    r.v = v; r.op = op; r.f = f; r.ms = ms; r.fs = fs; r.st = st; r.rv = rv; r.sel = sel; r.il = il;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_sc;

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; alu_op = '0;
    v1 = 1'b0; f1 = 1'b0; op1 = '0;

    //            v  op         f  ms fs st rv sel   il
    tbl[0]  = mk(1, 6'b000010, 0, 0, 0, 0, 1, 2'b00, 0); // ADD
    tbl[1]  = mk(1, 6'b010000, 0, 1, 0, 1, 0, 2'b00, 0); // MUL accept T0
    tbl[2]  = mk(1, 6'b000010, 0, 0, 0, 1, 0, 2'b00, 0); // op ignored in BUSY
    tbl[3]  = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[4]  = mk(0, 6'b000000, 0, 0, 0, 0, 1, 2'b01, 0); // MUL done T3
    tbl[5]  = mk(1, 6'b110000, 0, 0, 1, 1, 0, 2'b00, 0); // FADD T0
    tbl[6]  = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[7]  = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[8]  = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[9]  = mk(1, 6'b110001, 0, 0, 0, 0, 1, 2'b11, 0); // FADD done T4, FSUB waits
    tbl[10] = mk(1, 6'b110001, 0, 0, 1, 1, 0, 2'b00, 0); // FSUB T5
    tbl[11] = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[12] = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[13] = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[14] = mk(0, 6'b000000, 0, 0, 0, 0, 1, 2'b11, 0); // FSUB done T9
    tbl[15] = mk(1, 6'b111111, 0, 0, 0, 0, 0, 2'b00, 1);
    tbl[16] = mk(1, 6'b100000, 0, 0, 0, 0, 0, 2'b00, 1);
    tbl[17] = mk(1, 6'b010111, 0, 0, 0, 0, 0, 2'b00, 1); // 01_01xx is not a multiply
    tbl[18] = mk(1, 6'b000010, 1, 0, 0, 0, 0, 2'b00, 0); // flush in IDLE
    tbl[19] = mk(1, 6'b110000, 0, 0, 1, 1, 0, 2'b00, 0); // FADD T0
    tbl[20] = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[21] = mk(0, 6'b000000, 1, 0, 0, 1, 0, 2'b00, 0); // flush at T2
    tbl[22] = mk(1, 6'b000010, 0, 0, 0, 0, 1, 2'b00, 0); // ADD at T3
    tbl[23] = mk(1, 6'b010011, 0, 1, 0, 1, 0, 2'b00, 0); // MULHU
    tbl[24] = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[25] = mk(0, 6'b000000, 0, 0, 0, 1, 0, 2'b00, 0);
    tbl[26] = mk(0, 6'b000000, 1, 0, 0, 0, 0, 2'b01, 0); // flush in DONE
    tbl[27] = mk(0, 6'b000000, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[28] = mk(0, 6'b110000, 0, 0, 0, 0, 0, 2'b00, 0); // no valid

    #2;
    chk("rst_mul_start", {31'b0, mul_start}, 0);
    chk("rst_fp_start", {31'b0, fp_start}, 0);
    chk("rst_stall", {31'b0, ex_stall}, 0);
    chk("rst_rv", {31'b0, result_valid}, 0);
    chk("rst_sel", {30'b0, result_sel}, 0);
    chk("rst_ill", {31'b0, illegal_op}, 0);
    chk("rst_op", {26'b0, op_latched}, 0);
    chk("rst_sc", stall_count, 0);
    #10 rst_n = 1'b1;
    next_cycle();

    exp_sc = 0;
    for (int i = 0; i < 29; i++) begin
      ex_valid = tbl[i].v; alu_op = tbl[i].op; flush = tbl[i].f;
      @(negedge clk);
      chk($sformatf("v%0d_mul_start", i), {31'b0, mul_start}, {31'b0, tbl[i].ms});
      chk($sformatf("v%0d_fp_start", i), {31'b0, fp_start}, {31'b0, tbl[i].fs});
      chk($sformatf("v%0d_stall", i), {31'b0, ex_stall}, {31'b0, tbl[i].st});
      chk($sformatf("v%0d_rv", i), {31'b0, result_valid}, {31'b0, tbl[i].rv});
      chk($sformatf("v%0d_ill", i), {31'b0, illegal_op}, {31'b0, tbl[i].il});
      if (tbl[i].rv)
        chk($sformatf("v%0d_sel", i), {30'b0, result_sel}, {30'b0, tbl[i].sel});
      chk($sformatf("v%0d_sc", i), stall_count, exp_sc);
      if (i == 2)  chk("op_latched_mul", {26'b0, op_latched}, {26'b0, 6'b010000});
      if (i == 13) chk("op_latched_fsub", {26'b0, op_latched}, {26'b0, 6'b110001});
      if (i == 25) chk("op_latched_mulhu", {26'b0, op_latched}, {26'b0, 6'b010011});
      exp_sc += int'(tbl[i].st);
      next_cycle();
    end
    ex_valid = 1'b0; flush = 1'b0; alu_op = '0;
    @(negedge clk);
    chk("sc_total", stall_count, 17);

    // Async reset while the multiplier is running.
    next_cycle();
    ex_valid = 1'b1; alu_op = 6'b010001;
    @(negedge clk);
    chk("mulh_accept_start", {31'b0, mul_start}, 1);
    next_cycle();
    ex_valid = 1'b0;
    #1;
    chk("mulh_busy_stall", {31'b0, ex_stall}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, ex_stall}, 0);
    chk("midrst_rv", {31'b0, result_valid}, 0);
    chk("midrst_mul_start", {31'b0, mul_start}, 0);
    chk("midrst_sel", {30'b0, result_sel}, 0);
    chk("midrst_op", {26'b0, op_latched}, 0);
    chk("midrst_sc", stall_count, 0);
    #1 rst_n = 1'b1;
    next_cycle();
    ex_valid = 1'b1; alu_op = 6'b000010;
    @(negedge clk);
    chk("postrst_add_rv", {31'b0, result_valid}, 1);
    next_cycle();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("postrst_no_rv", {31'b0, result_valid}, 0);

    // MUL_LAT=1 instance: MULHU stalls one cycle then goes straight to DONE.
    next_cycle();
    v1 = 1'b1; op1 = 6'b010011;
    @(negedge clk);
    chk("l1_start", {31'b0, ms1}, 1);
    chk("l1_stall_t0", {31'b0, st1}, 1);
    chk("l1_rv_t0", {31'b0, rv1}, 0);
    next_cycle();
    v1 = 1'b0;
    @(negedge clk);
    chk("l1_stall_t1", {31'b0, st1}, 0);
    chk("l1_rv_t1", {31'b0, rv1}, 1);
    chk("l1_sel_t1", {30'b0, sel1}, 1);
    chk("l1_start_t1", {31'b0, ms1}, 0);
    next_cycle();
    @(negedge clk);
    chk("l1_rv_t2", {31'b0, rv1}, 0);
    chk("l1_sc", sc1, 1);
    chk("l1_op", {26'b0, ol1}, {26'b0, 6'b010011});
    chk("l1_fs_ill", {30'b0, fs1, il1}, 0);
    chk("l1_f_unused", {31'b0, f1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
